// File: rtl/dequant_lane_scheduler_if.sv
// Element-in / result-out streams of the dequant lane scheduler.
// The slave view belongs to the scheduler; the master view to whoever feeds and drains it.
interface dequant_lane_scheduler_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_level;
  logic             in_is_weight;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_level, in_is_weight, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_level, in_is_weight, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dequant_lane_scheduler.sv
// Packs a serial level stream into 4-lane groups for the dequantizer array, waits out its
// fixed latency, then re-serializes the 4 FP32 results in lane order. One group in flight.
module dequant_lane_scheduler #(
  parameter int DQ_LATENCY = 1,
  parameter int WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dequant_lane_scheduler_if.slave s,
  output logic [4*WIDTH-1:0]   dq_level,
  output logic [3:0]           dq_is_weight,
  input  logic [4*WIDTH-1:0]   dq_weight_fp,
  output logic                 dq_issue,
  output logic                 busy
);

  localparam int WCW = (DQ_LATENCY < 1) ? 1 : $clog2(DQ_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_GATHER = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         n_q, n_d;
  logic               grp_last_q, grp_last_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic               issue_q, issue_d;
  logic [1:0]         idx_q, idx_d;
  logic [4*WIDTH-1:0] lvl_q, lvl_d;
  logic [3:0]         isw_q, isw_d;
  logic [4*WIDTH-1:0] obuf_q, obuf_d;

  logic               at_end;

  assign at_end = ({1'b0, idx_q} == (n_q - 3'd1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    grp_last_d = grp_last_q;
    wcnt_d     = wcnt_q;
    issue_d    = 1'b0;
    idx_d      = idx_q;
    lvl_d      = lvl_q;
    isw_d      = isw_q;
    obuf_d     = obuf_q;

    case (state_q)
      ST_GATHER: begin
        if (s.in_valid) begin
          lvl_d[int'(cnt_q[1:0])*WIDTH +: WIDTH] = s.in_level;
          isw_d[cnt_q[1:0]]                      = s.in_is_weight;
          cnt_d                                  = cnt_q + 3'd1;
          if (cnt_q == 3'd3 || s.in_last) begin
            // Pad lanes above the last written one so the array sees clean zeros.
            for (int i = 0; i < 4; i++) begin
              if (i > int'(cnt_q)) begin
                lvl_d[i*WIDTH +: WIDTH] = '0;
                isw_d[i]                = 1'b0;
              end
            end
            n_d        = cnt_q + 3'd1;
            grp_last_d = s.in_last;
            wcnt_d     = WCW'(DQ_LATENCY);
            issue_d    = 1'b1;
            state_d    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCW'(1);
        end else begin
          obuf_d  = dq_weight_fp;
          idx_d   = 2'd0;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (s.out_ready) begin
          if (at_end) begin
            cnt_d   = 3'd0;
            state_d = ST_GATHER;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      default: state_d = ST_GATHER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_GATHER;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      grp_last_q <= 1'b0;
      wcnt_q     <= '0;
      issue_q    <= 1'b0;
      idx_q      <= 2'd0;
      lvl_q      <= '0;
      isw_q      <= 4'd0;
      obuf_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      grp_last_q <= grp_last_d;
      wcnt_q     <= wcnt_d;
      issue_q    <= issue_d;
      idx_q      <= idx_d;
      lvl_q      <= lvl_d;
      isw_q      <= isw_d;
      obuf_q     <= obuf_d;
    end
  end

  assign s.in_ready    = (state_q == ST_GATHER);
  assign s.out_valid   = (state_q == ST_DRAIN);
  assign s.out_data    = obuf_q[int'(idx_q)*WIDTH +: WIDTH];
  assign s.out_last    = (state_q == ST_DRAIN) && at_end && grp_last_q;
  assign dq_level      = lvl_q;
  assign dq_is_weight  = isw_q;
  assign dq_issue      = issue_q;
  assign busy          = (state_q != ST_GATHER) || (cnt_q != 3'd0);

endmodule
